// File: rtl/datapath.sv
// Multicycle CPU datapath: PC, IR, 8x register file, ALU, MDR, zero flag and memory port.
// Latency: ALU/mux paths combinational; PC/IR/regs/aluout/mdr/zero update on the next clk edge.
// Backpressure: none; the controller strobes are applied unconditionally every cycle.
module datapath #(
    parameter int                 DATA_W   = 16,
    parameter int                 ADDR_W   = 8,
    parameter logic [ADDR_W-1:0]  PC_RESET = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              writepc,
    input  logic              writeir,
    input  logic              writereg,
    input  logic              writemem,
    input  logic              writezero,
    input  logic              selalua,
    input  logic [1:0]        selalub,
    input  logic [1:0]        aluop,
    input  logic              selldst,
    input  logic              selload,
    input  logic              selst,
    output logic [5:0]        opcode,
    output logic              zero,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] pc_out
);

    localparam logic [1:0] ALU_AND = 2'b00;
    localparam logic [1:0] ALU_OR  = 2'b01;
    localparam logic [1:0] ALU_ADD = 2'b10;
    localparam logic [1:0] ALU_SUB = 2'b11;

    logic [ADDR_W-1:0] pc;
    logic [15:0]       ir;
    logic [DATA_W-1:0] regs [8];
    logic [DATA_W-1:0] aluout;
    logic [DATA_W-1:0] mdr;
    logic              zero_q;

    logic [2:0]        rd;
    logic [2:0]        rs;
    logic [2:0]        rt;
    logic [2:0]        regb_addr;
    logic [DATA_W-1:0] rega;
    logic [DATA_W-1:0] regb;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] alu_res;

    // Instruction field decode; stores read rd through port B so the store data is reg[rd].
    assign rd        = ir[9:7];
    assign rs        = ir[6:4];
    assign rt        = ir[3:1];
    assign regb_addr = selst ? rd : rt;
    assign rega      = regs[rs];
    assign regb      = regs[regb_addr];

    // ALU operand selection and operation; add/sub wrap modulo 2^DATA_W.
    always_comb begin
        alu_a   = '0;
        alu_b   = '0;
        alu_res = '0;
        alu_a   = selalua ? {{(DATA_W-ADDR_W){1'b0}}, pc} : rega;
        case (selalub)
            2'b00:   alu_b = regb;
            2'b01:   alu_b = {{(DATA_W-4){1'b0}}, ir[3:0]};
            2'b10:   alu_b = {{(DATA_W-1){1'b0}}, 1'b1};
            default: alu_b = {{(DATA_W-10){ir[9]}}, ir[9:0]};
        endcase
        case (aluop)
            ALU_AND: alu_res = alu_a & alu_b;
            ALU_OR:  alu_res = alu_a | alu_b;
            ALU_ADD: alu_res = alu_a + alu_b;
            ALU_SUB: alu_res = alu_a - alu_b;
            default: alu_res = '0;
        endcase
    end

    // Architectural state: strobed PC/IR/zero, free-running aluout/mdr capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc     <= PC_RESET;
            ir     <= '0;
            aluout <= '0;
            mdr    <= '0;
            zero_q <= 1'b0;
        end else begin
            aluout <= alu_res;
            mdr    <= mem_rdata;
            if (writepc)   pc     <= alu_res[ADDR_W-1:0];
            if (writeir)   ir     <= mem_rdata[15:0];
            if (writezero) zero_q <= (alu_res == '0);
        end
    end

    // Register file write port; the load path takes MDR, everything else takes aluout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) regs[i] <= '0;
        end else if (writereg) begin
            regs[rd] <= selload ? mdr : aluout;
        end
    end

    assign opcode    = ir[15:10];
    assign zero      = zero_q;
    assign mem_addr  = selldst ? aluout[ADDR_W-1:0] : pc;
    assign mem_wdata = regb;
    assign mem_we    = writemem;
    assign pc_out    = pc;

endmodule

// File: tb/tb_datapath.sv
// Directed bench for datapath: walks reset, fetch, ALU ops, store/load and branch/PC wrap.
// Latency: checks sampled 1 time unit after each rising edge (or combinationally mid-cycle).
// Backpressure: none; the bench plays the controller and an async-read memory.
module tb_datapath;

    localparam logic [1:0] AND_OP = 2'b00;
    localparam logic [1:0] ADD_OP = 2'b10;
    localparam logic [1:0] SUB_OP = 2'b11;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        writepc = 0, writeir = 0, writereg = 0, writemem = 0, writezero = 0;
    logic        selalua = 0, selldst = 0, selload = 0, selst = 0;
    logic [1:0]  selalub = 2'b00, aluop = AND_OP;
    logic [5:0]  opcode;
    logic        zero;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic [15:0] mem_rdata;
    logic [7:0]  pc_out;

    logic [15:0] mem [256];

    int total = 0;
    int bad   = 0;

    datapath #(.DATA_W(16), .ADDR_W(8), .PC_RESET(8'h00)) dut (
        .clk(clk), .rst_n(rst_n),
        .writepc(writepc), .writeir(writeir), .writereg(writereg),
        .writemem(writemem), .writezero(writezero),
        .selalua(selalua), .selalub(selalub), .aluop(aluop),
        .selldst(selldst), .selload(selload), .selst(selst),
        .opcode(opcode), .zero(zero), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
        .pc_out(pc_out)
    );

    always #5 clk = ~clk;

    // Async-read, sync-write memory model.
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one controller state's strobes/selects.
    task automatic drive(input logic wpc, input logic wir, input logic wreg, input logic wmem,
                         input logic wz, input logic sa, input logic [1:0] sb, input logic [1:0] op,
                         input logic sld, input logic slo, input logic sst);
        writepc = wpc; writeir = wir; writereg = wreg; writemem = wmem; writezero = wz;
        selalua = sa; selalub = sb; aluop = op; selldst = sld; selload = slo; selst = sst;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch();
        drive(1, 1, 0, 0, 0, 1, 2'b10, ADD_OP, 0, 0, 0);
        tick();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[0]   = 16'h1485;  // addi r1,r0,5
        mem[1]   = 16'h1912;  // sub  r2,r1,r1
        mem[2]   = 16'h2089;  // sw   r1,[r0+9]
        mem[3]   = 16'h1D89;  // lw   r3,[r0+9]
        mem[4]   = 16'h13FE;  // beq  -2
        mem[255] = 16'h0C00;  // opcode 3

        // Reset state
        #12;
        chk("rst_pc", pc_out, 8'h00);
        chk("rst_opcode", opcode, 6'h00);
        chk("rst_zero", zero, 1'b0);
        chk("rst_we", mem_we, 1'b0);
        chk("rst_addr", mem_addr, 8'h00);
        rst_n = 1'b1;
        tick();

        // T1: build up state, then reset asynchronously between edges
        drive(0, 0, 0, 0, 1, 0, 2'b00, SUB_OP, 0, 0, 0);   // r0-r0 -> zero=1
        tick();
        chk("pre_zero", zero, 1'b1);
        fetch();
        chk("pre_pc", pc_out, 8'h01);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_pc", pc_out, 8'h00);
        chk("arst_zero", zero, 1'b0);
        chk("arst_we", mem_we, 1'b0);
        chk("arst_opcode", opcode, 6'h00);
        drive(0, 0, 0, 0, 0, 0, 2'b00, AND_OP, 0, 0, 0);
        rst_n = 1'b1;

        // T2: fetch addi
        fetch();
        chk("f0_ir_opcode", opcode, 6'h05);
        chk("f0_pc", pc_out, 8'h01);

        // T3: addi r1,r0,5 exec + writeback
        drive(0, 0, 0, 0, 0, 0, 2'b01, ADD_OP, 0, 0, 0);
        tick();
        drive(0, 0, 1, 0, 1, 0, 2'b01, ADD_OP, 0, 0, 0);
        tick();
        chk("addi_zero", zero, 1'b0);
        drive(0, 0, 0, 0, 0, 0, 2'b00, AND_OP, 0, 0, 1);   // port B reads rd=r1
        chk("addi_r1", mem_wdata, 16'h0005);

        // T4: fetch sub, exec + writeback
        fetch();
        chk("f1_opcode", opcode, 6'h06);
        chk("f1_pc", pc_out, 8'h02);
        drive(0, 0, 0, 0, 0, 0, 2'b00, SUB_OP, 0, 0, 0);
        tick();
        drive(0, 0, 1, 0, 1, 0, 2'b00, SUB_OP, 0, 0, 0);
        tick();
        chk("sub_zero", zero, 1'b1);
        drive(0, 0, 0, 0, 0, 0, 2'b00, AND_OP, 0, 0, 1);
        chk("sub_r2", mem_wdata, 16'h0000);
        drive(0, 0, 0, 0, 0, 0, 2'b00, AND_OP, 0, 0, 0);
        chk("sub_rt_r1", mem_wdata, 16'h0005);

        // T5: store r1 -> [r0+9]
        fetch();
        chk("f2_opcode", opcode, 6'h08);
        chk("f2_pc", pc_out, 8'h03);
        drive(0, 0, 0, 0, 0, 0, 2'b01, ADD_OP, 0, 0, 1);
        tick();
        drive(0, 0, 0, 1, 0, 0, 2'b01, ADD_OP, 1, 0, 1);
        chk("st_addr", mem_addr, 8'h09);
        chk("st_wdata", mem_wdata, 16'h0005);
        chk("st_we", mem_we, 1'b1);
        tick();
        drive(0, 0, 0, 0, 0, 0, 2'b00, AND_OP, 0, 0, 0);
        chk("st_we_drop", mem_we, 1'b0);
        chk("st_mem9", mem[9], 16'h0005);

        // T5: load r3 <- [r0+9]
        fetch();
        chk("f3_opcode", opcode, 6'h07);
        drive(0, 0, 0, 0, 0, 0, 2'b01, ADD_OP, 1, 1, 0);   // address calc
        tick();
        drive(0, 0, 0, 0, 0, 0, 2'b01, ADD_OP, 1, 1, 0);   // memory read into mdr
        chk("ld_addr", mem_addr, 8'h09);
        tick();
        drive(0, 0, 1, 0, 0, 0, 2'b01, ADD_OP, 1, 1, 0);   // writeback from mdr
        tick();
        drive(0, 0, 0, 0, 0, 0, 2'b00, AND_OP, 0, 0, 1);
        chk("ld_r3", mem_wdata, 16'h0005);

        // T6: beq -2 from post-fetch pc 5, then walk PC down through zero to 0xFF
        fetch();
        chk("f4_opcode", opcode, 6'h04);
        chk("f4_pc", pc_out, 8'h05);
        chk("beq_zero_held", zero, 1'b1);
        drive(1, 0, 0, 0, 0, 1, 2'b11, ADD_OP, 0, 0, 0);
        tick();
        chk("beq_pc", pc_out, 8'h03);
        tick();
        chk("beq_pc2", pc_out, 8'h01);
        tick();
        chk("beq_pc_ff", pc_out, 8'hFF);
        chk("addr_ff", mem_addr, 8'hFF);
        fetch();
        chk("wrap_pc", pc_out, 8'h00);
        chk("wrap_opcode", opcode, 6'h03);
        drive(0, 0, 0, 0, 0, 0, 2'b00, AND_OP, 0, 0, 0);
        tick();
        chk("hold_pc", pc_out, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
